// File: rtl/gpr_file_pkg.sv
// gpr_file_pkg: shared register-file widths, enables, constants and scrub FSM encoding
package gpr_file_pkg;

    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_NUM    = 32;

    typedef logic [REG_W-1:0]      reg_bus_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_bus_t;

    localparam logic RST_ENABLE = 1'b1;
    localparam logic WR_ENABLE  = 1'b1;
    localparam logic WR_DISABLE = 1'b0;
    localparam logic RD_ENABLE  = 1'b1;
    localparam logic RD_DISABLE = 1'b0;

    localparam reg_bus_t      ZERO_WORD      = '0;
    localparam reg_addr_bus_t NOP_REG_ADDR   = '0;
    localparam reg_addr_bus_t GPR_SCRUB_LAST = 5'd31;

    typedef enum logic {
        GPR_STATE_SCRUB = 1'b0,
        GPR_STATE_RUN   = 1'b1
    } gpr_state_e;

endpackage

// File: rtl/gpr_scrub_ctrl.sv
// gpr_scrub_ctrl: post-reset sequencer that zeroes r1..r31 one per cycle and holds the pipeline meanwhile
module gpr_scrub_ctrl
    import gpr_file_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    output logic          scrub_we,
    output reg_addr_bus_t scrub_addr,
    output logic          in_scrub,
    output logic          stall_req_o,
    output logic          ready_o
);

    gpr_state_e    state, state_nxt;
    reg_addr_bus_t scrub_cnt, scrub_cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state     <= GPR_STATE_SCRUB;
            scrub_cnt <= reg_addr_bus_t'(1);
            ready_o   <= 1'b0;
        end else begin
            state     <= state_nxt;
            scrub_cnt <= scrub_cnt_nxt;
            ready_o   <= state_nxt == GPR_STATE_RUN;
        end
    end

    // counter parks on the last register so it never wraps back to r0
    always_comb begin
        state_nxt     = (state == GPR_STATE_SCRUB && scrub_cnt == GPR_SCRUB_LAST) ? GPR_STATE_RUN : state;
        scrub_cnt_nxt = (state == GPR_STATE_SCRUB && scrub_cnt != GPR_SCRUB_LAST) ? scrub_cnt + 1'b1 : scrub_cnt;
    end

    always_comb begin
        in_scrub    = rst == RST_ENABLE || state == GPR_STATE_SCRUB;
        scrub_we    = rst != RST_ENABLE && state == GPR_STATE_SCRUB;
        scrub_addr  = scrub_cnt;
        stall_req_o = in_scrub;
    end

endmodule

// File: rtl/gpr_file.sv
// gpr_file: 32x32 register file, two combinational read ports with write-through bypass, one write port
module gpr_file
    import gpr_file_pkg::*;
#(
    parameter int DATA_W = REG_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int NREGS  = REG_NUM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re1_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic              re2_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata2_o,
    output logic              stall_req_o,
    output logic              ready_o
);

    logic [DATA_W-1:0] regs [NREGS];
    logic              scrub_we, in_scrub, wr_en, hit1, hit2;
    reg_addr_bus_t     scrub_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    gpr_scrub_ctrl u_scrub (
        .clk         (clk),
        .rst         (rst),
        .scrub_we    (scrub_we),
        .scrub_addr  (scrub_addr),
        .in_scrub    (in_scrub),
        .stall_req_o (stall_req_o),
        .ready_o     (ready_o)
    );

    // single write port shared by scrub and write-back keeps storage RAM-mappable
    always_comb begin
        wr_en   = scrub_we || (!in_scrub && we_i == WR_ENABLE && waddr_i != ADDR_W'(NOP_REG_ADDR));
        wr_addr = scrub_we ? ADDR_W'(scrub_addr) : waddr_i;
        wr_data = scrub_we ? '0 : wdata_i;
    end

    always_ff @(posedge clk) begin
        if (wr_en) regs[wr_addr] <= wr_data;
    end

    always_comb begin
        hit1     = we_i == WR_ENABLE && waddr_i == raddr1_i;
        hit2     = we_i == WR_ENABLE && waddr_i == raddr2_i;
        rdata1_o = (in_scrub || re1_i != RD_ENABLE || raddr1_i == ADDR_W'(NOP_REG_ADDR)) ? '0 :
                   hit1 ? wdata_i : regs[raddr1_i];
        rdata2_o = (in_scrub || re2_i != RD_ENABLE || raddr2_i == ADDR_W'(NOP_REG_ADDR)) ? '0 :
                   hit2 ? wdata_i : regs[raddr2_i];
    end

endmodule

// File: doc/gpr_file.md
Name: gpr_file

Overview:
- General-purpose register file: the responder side of the decode stage's register-read interface (re1/re2, raddr1/raddr2, rdata1/rdata2). It also sinks the write-back stage's write port.
- Provides 32 x 32-bit registers, two combinational read ports and one synchronous write port.
- Hardwires $zero to 0 and bypasses a same-cycle write-back value to the read ports.
- After reset, a scrub sequencer clears registers 1..31 one per cycle. Storage therefore maps to RAM without a per-bit reset, and the pipeline is held via stall_req_o during the scrub.

Parameters:
- DATA_W, 32, register width.
- ADDR_W, 5, register address width.
- NREGS, 32, register count (2**ADDR_W).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high (RST_ENABLE); sampled only at posedge.
- we_i  in  1  write-back write enable (WR_ENABLE).
- waddr_i  in  ADDR_W  write-back destination register.
- wdata_i  in  DATA_W  write-back data.
- re1_i  in  1  read port 1 enable (RD_ENABLE).
- raddr1_i  in  ADDR_W  read port 1 address.
- rdata1_o  out  DATA_W  read port 1 data, combinational.
- re2_i  in  1  read port 2 enable.
- raddr2_i  in  ADDR_W  read port 2 address.
- rdata2_o  out  DATA_W  read port 2 data, combinational.
- stall_req_o  out  1  high while the scrub is in progress; pipeline control freezes PC/IF/ID.
- ready_o  out  1  registered; high once the scrub is complete and the file is in RUN.

Behaviour:
- FSM states: SCRUB, RUN.
- rst=1 at posedge:
  - state <= SCRUB, scrub_cnt <= 1, ready_o <= 0.
  - Register contents are not touched by the reset itself.
  - While rst is high, rdata1_o/rdata2_o = ZERO_WORD and stall_req_o = 1 (combinational on rst).
- SCRUB, each posedge with rst=0:
  - regs[scrub_cnt] <= 0, then scrub_cnt++.
  - When scrub_cnt == NREGS-1 is written: state <= RUN, ready_o <= 1.
  - The scrub therefore takes 31 cycles after rst deasserts.
  - stall_req_o = 1 throughout SCRUB.
  - we_i is ignored in SCRUB; no write occurs.
  - Reads return ZERO_WORD.
- RUN:
  - stall_req_o = 0.
  - Write: at posedge, if we_i=1 and waddr_i != 0, regs[waddr_i] <= wdata_i. Writes to r0 are dropped.
- Read port n, combinational, in priority order:
  1. rst=1 or state=SCRUB -> ZERO_WORD.
  2. re_n=0 -> ZERO_WORD.
  3. raddr_n=0 -> ZERO_WORD.
  4. we_i=1 and waddr_i == raddr_n -> wdata_i (write-through bypass).
  5. Otherwise -> regs[raddr_n].
- Both ports may read the same address; both receive an identical value and bypass applies to both.
- A write is visible through regs[] on the cycle after the posedge that performs it; bypass covers the same cycle.
- Reset mid-scrub: scrub restarts from register 1 and the full 31 cycles are required again.
- Reset in RUN: contents are cleared only by the subsequent scrub, never by rst directly.
- No read or write side effects on r0 under any condition.
- scrub_cnt is ADDR_W wide and never wraps: it stops advancing in RUN.

Decomposition:
- Shared defines file (already holds RST_ENABLE, WR_ENABLE/WR_DISABLE, RD_ENABLE/RD_DISABLE, ZERO_WORD, NOP_REG_ADDR, REG_BUS, REG_ADDR_BUS). Add:
  - REG_NUM (32)
  - GPR_STATE_SCRUB / GPR_STATE_RUN state encodings
  - GPR_SCRUB_LAST (5'd31)
- One sub-module, gpr_scrub_ctrl, holds the FSM, scrub_cnt, ready_o and stall_req_o. Its outputs are a scrub write enable, scrub address and in_scrub flag. gpr_file muxes the scrub write against the write-back write.

Test Plan:
- rst high 2 cycles, release -> stall_req_o=1 for exactly 31 cycles, then ready_o=1 and stall_req_o=0. Read r1..r31 with re=1 -> all 0x00000000.
- RUN: write r5=0xDEADBEEF, next cycle raddr1=5, re1=1 -> rdata1_o=0xDEADBEEF. Same cycle with re1=0 -> 0x00000000.
- Same-cycle bypass: we_i=1, waddr_i=7, wdata_i=0x12345678, raddr1=raddr2=7 -> both read ports return 0x12345678 combinationally, before the posedge.
- r0: write waddr_i=0, wdata_i=0xFFFFFFFF -> read r0 (both the same cycle and the next cycle) returns 0x00000000; no bypass.
- Reset mid-scrub: assert rst at scrub cycle 10 for 1 cycle -> the scrub restarts and stall_req_o stays high 31 more cycles. A we_i=1 write to r3=0xAA during the scrub is dropped; reading r3 after ready_o=1 -> 0x00000000.
- Reset in RUN: write r9=0x55, assert rst -> rdata outputs are 0 while rst=1. After the scrub completes, r9 reads 0x00000000.
